// File: rtl/bram_rmw_ctrl.sv
// Read-modify-write requester for the dual-port CAM table BRAM.
// Port 0 reads, port 1 writes back. After reset the whole RAM is swept to zero,
// then READ/WRITE/SET/CLR commands flow through a two-stage pipeline at one
// command per cycle. Each command answers with the word as it was before the command.
module bram_rmw_ctrl #(
   parameter int Depth = 512,
   parameter int Width = 36,
   localparam int AW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [AW-1:0]    req_addr,
   input  logic [Width-1:0] req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [Width-1:0] rsp_data,
   output logic             init_done,
   output logic             en_0,
   output logic             wen_0,
   output logic [AW-1:0]    addr_0,
   output logic [Width-1:0] din_0,
   input  logic [Width-1:0] dout_0,
   output logic             en_1,
   output logic             wen_1,
   output logic [AW-1:0]    addr_1,
   output logic [Width-1:0] din_1,
   input  logic [Width-1:0] dout_1
);

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLR   = 2'b11
   } op_t;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t           state;
   logic [AW-1:0]    cnt;

   logic             s1_valid;
   op_t              s1_op;
   logic [AW-1:0]    s1_addr;
   logic [Width-1:0] s1_data;

   logic             bypass;
   logic [Width-1:0] fwd_data;

   logic [Width-1:0] old_word;
   logic [Width-1:0] new_word;
   logic             s1_go;
   logic             wr_fire;
   logic             hazard;

   // Port 1 read data is never needed; the write-back path is port 1 only.
   logic unused_dout_1;
   assign unused_dout_1 = ^dout_1;

   // Pipeline steering and BRAM drive: the sweep owns port 1 during INIT,
   // the S1 write-back owns it during RUN, and a collision arms the bypass.
   always_comb begin
      old_word = bypass ? fwd_data : dout_0;
      new_word = old_word;
      case (s1_op)
         OP_READ:  new_word = old_word;
         OP_WRITE: new_word = s1_data;
         OP_SET:   new_word = old_word | s1_data;
         OP_CLR:   new_word = old_word & ~s1_data;
         default:  new_word = old_word;
      endcase

      s1_go     = s1_valid && (!rsp_valid || rsp_ready);
      wr_fire   = s1_go && (s1_op != OP_READ);
      req_ready = (state == ST_RUN) && (!s1_valid || s1_go);

      en_0   = req_valid && req_ready;
      wen_0  = 1'b0;
      din_0  = '0;
      addr_0 = en_0 ? req_addr : '0;

      en_1   = 1'b0;
      wen_1  = 1'b0;
      addr_1 = '0;
      din_1  = '0;
      if (state == ST_INIT) begin
         en_1   = rst_n;
         wen_1  = rst_n;
         addr_1 = cnt;
      end else if (wr_fire) begin
         en_1   = 1'b1;
         wen_1  = 1'b1;
         addr_1 = s1_addr;
         din_1  = new_word;
      end

      hazard = wr_fire && en_0 && (req_addr == s1_addr);
   end

   // Sweep FSM, S1 capture, bypass flag and response register; the bypass
   // only changes when S1 is refilled or emptied, so a stalled S1 keeps it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         cnt       <= '0;
         init_done <= 1'b0;
         s1_valid  <= 1'b0;
         s1_op     <= OP_READ;
         s1_addr   <= '0;
         s1_data   <= '0;
         bypass    <= 1'b0;
         fwd_data  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (state == ST_INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(Depth - 1)) begin
               state     <= ST_RUN;
               init_done <= 1'b1;
            end
         end

         if (en_0) begin
            s1_valid <= 1'b1;
            s1_op    <= op_t'(req_op);
            s1_addr  <= req_addr;
            s1_data  <= req_data;
            bypass   <= hazard;
            fwd_data <= din_1;
         end else if (s1_go) begin
            s1_valid <= 1'b0;
            bypass   <= 1'b0;
         end

         if (s1_go) begin
            rsp_valid <= 1'b1;
            rsp_data  <= old_word;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Self-checking bench for bram_rmw_ctrl: models the BRAM, keeps a word-array
// reference of the table, and checks the response stream plus directed corner cases.
module tb_bram_rmw_ctrl;

   localparam int DEPTH = 512;
   localparam int W     = 36;
   localparam int AW    = 9;

   localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;

   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } cmd_t;

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      logic [W-1:0]  exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready, rsp_valid, rsp_ready, init_done;
   logic [1:0]    req_op;
   logic [AW-1:0] req_addr, addr_0, addr_1;
   logic [W-1:0]  req_data, rsp_data, din_0, din_1, dout_0, dout_1;
   logic          en_0, wen_0, en_1, wen_1;

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  ref_mem [DEPTH];
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  rsp_log[$];
   cmd_t          cmdq[$];
   vec_t          vecs[10];

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int wr_cnt = 0;

   always #5 clk = ~clk;

   bram_rmw_ctrl #(.Depth(DEPTH), .Width(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .init_done(init_done),
      .en_0(en_0), .wen_0(wen_0), .addr_0(addr_0), .din_0(din_0), .dout_0(dout_0),
      .en_1(en_1), .wen_1(wen_1), .addr_1(addr_1), .din_1(din_1), .dout_1(dout_1)
   );

   // BRAM model: 1-cycle read-first port 0, output held while disabled; port 1 writes.
   assign dout_1 = '0;
   always @(posedge clk) begin
      if (en_0) dout_0 <= mem[addr_0];
      if (en_1 && wen_1) mem[addr_1] <= din_1;
   end

   function automatic logic [W-1:0] applyOp(input logic [1:0] op, input logic [W-1:0] old,
                                            input logic [W-1:0] d);
      case (op)
         RD:      return old;
         WR:      return d;
         ST:      return old | d;
         default: return old & ~d;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: apply each accepted command to the word array and expect the old word back.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else begin
         if (req_valid && req_ready) begin
            acc_cnt++;
            exp_q.push_back(ref_mem[req_addr]);
            ref_mem[req_addr] = applyOp(req_op, ref_mem[req_addr], req_data);
         end
         if (rsp_valid && rsp_ready) begin
            rsp_log.push_back(rsp_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL rsp_unexpected: got 0x%0h expected no response", rsp_data);
            end else begin
               checkOutput("rsp_stream", 64'(rsp_data), 64'(exp_q.pop_front()));
            end
         end
         if (init_done && en_1 && wen_1) wr_cnt++;
      end
   end

   // One clock: drive the head command with probability p_valid, rsp_ready with p_ready.
   task automatic applyStimulus(input int p_valid, input int p_ready);
      bit   fire;
      cmd_t c;
      if (cmdq.size() > 0 && $urandom_range(99) < p_valid) begin
         c         = cmdq[0];
         req_valid = 1'b1;
         req_op    = c.op;
         req_addr  = c.addr;
         req_data  = c.data;
      end else begin
         req_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(99) < p_ready);
      @(negedge clk);
      fire = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (fire) void'(cmdq.pop_front());
      req_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((cmdq.size() > 0 || exp_q.size() > 0) && n < bound) begin
         applyStimulus(100, 100);
         n++;
      end
      checks++;
      if (cmdq.size() > 0 || exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d cmds %0d rsps pending expected 0", cmdq.size(), exp_q.size());
      end
   endtask

   task automatic issueAndCheck(input string name, input cmd_t c, input logic [W-1:0] exp);
      int n = 0;
      int base = rsp_log.size();
      cmdq.push_back(c);
      while (rsp_log.size() == base && n < 20) begin
         applyStimulus(100, 100);
         n++;
      end
      if (rsp_log.size() == base) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got no response expected 0x%0h", name, exp);
      end else begin
         checkOutput(name, 64'(rsp_log[base]), 64'(exp));
      end
   endtask

   task automatic waitInit(input int bound);
      int n = 0;
      while (!init_done && n < bound) begin
         applyStimulus(0, 100);
         n++;
      end
      checkOutput("init_done_wait", 64'(init_done), 64'd1);
   endtask

   initial begin
      int            n, nz, acc0, wr0, base;
      bit            done;
      logic          prev_done;
      logic [63:0]   r;

      vecs[0] = '{WR, 9'h010, 36'hA5A5A5A5A, 36'h0};
      vecs[1] = '{RD, 9'h010, 36'h0,         36'hA5A5A5A5A};
      vecs[2] = '{ST, 9'h020, 36'h1,         36'h0};
      vecs[3] = '{ST, 9'h020, 36'h2,         36'h1};
      vecs[4] = '{CL, 9'h020, 36'h1,         36'h3};
      vecs[5] = '{RD, 9'h020, 36'h0,         36'h2};
      vecs[6] = '{RD, 9'h1FF, 36'h0,         36'h0};
      vecs[7] = '{WR, 9'h1FF, 36'hFFFFFFFFF, 36'h0};
      vecs[8] = '{CL, 9'h1FF, 36'h0F0F0F0F0, 36'hFFFFFFFFF};
      vecs[9] = '{RD, 9'h1FF, 36'h0,         36'hF0F0F0F0F};

      for (int i = 0; i < DEPTH; i++) begin
         r = {$urandom, $urandom};
         mem[i] = r[W-1:0] | 36'h1;
      end
      dout_0    = 36'h123456789;
      req_valid = 1'b0;
      req_op    = RD;
      req_addr  = '0;
      req_data  = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
      checkOutput("reset_init_done", 64'(init_done), 64'd0);
      checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
      checkOutput("reset_bram_drive", 64'({en_0, wen_0, en_1, wen_1, addr_0, addr_1, din_0, din_1} != 0), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Clear sweep: req_ready low for DEPTH cycles, starting at address 0
      n = 0;
      done = 0;
      prev_done = 1'b1;
      while (!done && n < 1000) begin
         @(negedge clk);
         if (req_ready) begin
            done = 1;
         end else begin
            if (n == 0) checkOutput("init_first_addr", 64'({en_1, wen_1, addr_1}), {53'd0, 2'b11, 9'd0});
            prev_done = init_done;
            n++;
         end
      end
      checkOutput("init_ready_low_cycles", 64'(n), 64'(DEPTH));
      checkOutput("init_done_before_end", 64'(prev_done), 64'd0);
      checkOutput("init_done_after", 64'(init_done), 64'd1);
      @(posedge clk);
      #1;
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
      checkOutput("bram_cleared_words", 64'(nz), 64'd0);

      issueAndCheck("read_last_after_init", '{RD, 9'h1FF, 36'h0}, 36'h0);

      // Latency: accept at t, response at t+2
      cmdq.push_back('{RD, 9'h011, 36'h0});
      acc0 = acc_cnt;
      applyStimulus(100, 100);
      checkOutput("latency_accept", 64'(acc_cnt - acc0), 64'd1);
      @(negedge clk);
      checkOutput("latency_t1_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("latency_t2_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1;
      drain(20);

      // Vector table back-to-back: one accept per cycle, bypass on repeated addresses
      base = rsp_log.size();
      for (int i = 0; i < 10; i++) cmdq.push_back('{vecs[i].op, vecs[i].addr, vecs[i].data});
      n = 0;
      while (cmdq.size() > 0 && n < 50) begin
         applyStimulus(100, 100);
         n++;
      end
      checkOutput("table_throughput_cycles", 64'(n), 64'd10);
      drain(20);
      for (int i = 0; i < 10; i++) begin
         if (rsp_log.size() > base + i) checkOutput($sformatf("table_vec%0d", i), 64'(rsp_log[base + i]), 64'(vecs[i].exp));
         else checkOutput($sformatf("table_vec%0d_missing", i), 64'(rsp_log.size()), 64'(base + 10));
      end

      // Backpressure: 5 stalled cycles with 3 WRITEs offered
      cmdq.push_back('{WR, 9'h040, 36'h111});
      cmdq.push_back('{WR, 9'h041, 36'h222});
      cmdq.push_back('{WR, 9'h042, 36'h333});
      drain(30);
      base = rsp_log.size();
      cmdq.push_back('{WR, 9'h040, 36'hAAA});
      cmdq.push_back('{WR, 9'h041, 36'hBBB});
      cmdq.push_back('{WR, 9'h042, 36'hCCC});
      acc0 = acc_cnt;
      wr0  = wr_cnt;
      repeat (5) applyStimulus(100, 0);
      checkOutput("stall_accepted", 64'(acc_cnt - acc0), 64'd2);
      checkOutput("stall_bram_writes", 64'(wr_cnt - wr0), 64'd1);
      checkOutput("stall_rsp_held", 64'(rsp_valid), 64'd1);
      drain(30);
      checkOutput("stall_order_0", 64'(rsp_log[base]), 64'h111);
      checkOutput("stall_order_1", 64'(rsp_log[base + 1]), 64'h222);
      checkOutput("stall_order_2", 64'(rsp_log[base + 2]), 64'h333);
      issueAndCheck("stall_final_value", '{RD, 9'h042, 36'h0}, 36'hCCC);

      // Reset one cycle after a WRITE is accepted
      cmdq.push_back('{WR, 9'h033, 36'h9ABCDEF01});
      drain(20);
      cmdq.push_back('{WR, 9'h033, 36'h5});
      acc0 = acc_cnt;
      base = rsp_log.size();
      applyStimulus(100, 100);
      checkOutput("rst_write_accepted", 64'(acc_cnt - acc0), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_bram_write", 64'({en_1, wen_1}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_sweep_addr0", 64'({en_1, addr_1}), {54'd0, 1'b1, 9'd0});
      checkOutput("rst_no_rsp", 64'(rsp_log.size() - base), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_sweep_addr1", 64'(addr_1), 64'd1);
      @(posedge clk);
      #1;
      waitInit(600);
      issueAndCheck("rst_word_cleared", '{RD, 9'h033, 36'h0}, 36'h0);

      // Random traffic against the reference array
      acc0 = acc_cnt;
      for (int i = 0; i < 400; i++) begin
         r = {$urandom, $urandom};
         cmdq.push_back('{2'($urandom_range(3)),
                          ($urandom_range(1) == 1) ? AW'($urandom_range(15)) : AW'($urandom_range(DEPTH - 1)),
                          r[W-1:0]});
      end
      n = 0;
      while (cmdq.size() > 0 && n < 5000) begin
         applyStimulus(70, 60);
         n++;
      end
      drain(200);
      checkOutput("random_accepted", 64'(acc_cnt - acc0), 64'd400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
